vga_plot_arbiter: RTL
=====================

# vga_plot_arbiter

Shares the single VGA adapter write port between the game's pixel producers: the falling-block draw/erase FSM, the board redraw (line-clear) engine, the score/status painter, and a built-in full-screen clear engine. Each requester holds exclusive ownership of the port for the whole of its burst. Ownership is granted round-robin with a guaranteed idle cycle between owners. All VGA outputs are registered so the adapter sees glitch-free, single-owner writes.

## Interface
- XSCREEN, 160: screen width in pixels; clear-sweep X limit.
- YSCREEN, 120: screen height in pixels; clear-sweep Y limit.
- CLEAR_COLOUR, 3'b000: colour written by the clear engine.
- CLOCK_50  in  1  system clock.
- Resetn  in  1  reset; synchronous, active-low, sampled on CLOCK_50 rising edge.
- req  in  3  request per external requester: [0] block FSM, [1] board redraw, [2] score painter.
- x0, x1, x2  in  8 each  pixel X of requester i.
- y0, y1, y2  in  7 each  pixel Y of requester i.
- c0, c1, c2  in  3 each  colour of requester i.
- p0, p1, p2  in  1 each  plot strobe of requester i.
- clear_start  in  1  one-cycle pulse requesting a full-screen clear.
- gnt  out  3  one-hot grant to external requesters.
- clear_busy  out  1  high from accepted clear_start until the sweep ends.
- clear_done  out  1  one-cycle pulse after the last clear pixel.
- vga_x  out  8  registered X to the adapter.
- vga_y  out  7  registered Y to the adapter.
- vga_colour  out  3  registered colour to the adapter.
- vga_plot  out  1  registered write enable to the adapter.

## Operation
- Four slots: 0–2 external, 3 internal clear engine. Slot 3 requests while clear_pending=1.
- clear_start sets clear_pending and clear_busy. It is ignored while clear_busy=1.
- FSM states are IDLE, GRANT, RELEASE.
- IDLE: on any active request, select the first active slot searching upward from last_owner+1 (mod 4). Move to GRANT and set owner. With no request, stay in IDLE.
- GRANT, external owner i:
  - gnt[i]=1.
  - Forward xi/yi/ci/pi into the output registers every cycle.
  - p strobes from non-owners are discarded; no buffering.
  - When req[i] falls, go to RELEASE.
- GRANT, clear owner:
  - Sweep x 0..XSCREEN-1 inner, y 0..YSCREEN-1 outer, one pixel per cycle, with vga_plot=1 and vga_colour=CLEAR_COLOUR.
  - The last pixel is (XSCREEN-1, YSCREEN-1).
  - After the last pixel, clear clear_pending and clear_busy, pulse clear_done, and go to RELEASE.
- RELEASE: gnt=0 and vga_plot=0 for exactly one cycle. Record last_owner=owner, then go to IDLE.
- A requester raising req while another slot owns the port waits and is never preempted. The clear engine also waits its round-robin turn.
- Sweep counters are 8-bit X and 7-bit Y. They wrap to 0 at end of row/sweep.
- Reset state:
  - IDLE; last_owner=3, so slot 0 is searched first after reset.
  - gnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
  - clear_pending=0, clear_busy=0, clear_done=0, sweep counters 0.
- Reset mid-burst or mid-clear aborts immediately. An aborted clear is not resumed.

## Timing
- Request to grant: req sampled high in IDLE at cycle t gives gnt high at t+1. Minimum latency is 1 cycle.
- Data path: owner's pixel/strobe at cycle t appears on vga_* at t+1. Fixed one-cycle latency; the adapter sees at most one plot per cycle.
- Release: req low at t gives gnt low at t+1 (RELEASE). The next owner's gnt rises no earlier than t+3.
- Clear sweep:
  - The first clear pixel appears on vga_* 1 cycle after entering GRANT.
  - The sweep is XSCREEN×YSCREEN = 19200 consecutive plot cycles.
  - clear_done rises in the cycle the final pixel is on vga_*.
- Simultaneous events:
  - req rising in the same cycle another owner releases is served by round-robin order in the following IDLE.
  - clear_start arriving in the same cycle as clear_done is ignored.
- gnt is always zero or one-hot. vga_plot is never high in IDLE or RELEASE outputs.

## Test plan
- Reset, then req=3'b001 with p0=1, x0=5, y0=7, c0=3'b100:
  - gnt=001 one cycle after req.
  - Next cycle vga_x=5, vga_y=7, vga_colour=4, vga_plot=1.
  - All outputs 0 during reset.
- req=3'b111 held, each requester releasing after 4 cycles:
  - Grant order 0,1,2,0.
  - One gnt=000 cycle between owners.
  - gnt never multi-hot.
- Owner 0 active while p1=1 pulsing: no vga_plot from requester 1 data, and vga_x tracks x0 only.
- clear_start with no other requests:
  - 19200 plots, first (0,0), row wrap (159,0)→(0,1), last (159,119), all colour 0.
  - clear_done one pulse; clear_busy falls with it.
- Owner 1 holding, clear_start pulsed, a second clear_start pulsed mid-sweep, req0 raised during the sweep:
  - The clear waits for owner 1 to release.
  - Only one sweep occurs.
  - Requester 0 is granted only after clear RELEASE.
- Resetn low at sweep pixel 1000: next cycle all outputs 0, clear_busy=0, and no clear_done pulse.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single VGA adapter write port between three external pixel
//   producers and an internal full-screen clear engine. Ownership is granted
//   round-robin. An owner keeps the port for its whole burst, and every
//   hand-over includes a dead cycle. All adapter-facing outputs are registered.
//
// Ports
//   CLOCK_50        system clock
//   Resetn          synchronous, active-low reset
//   req[2:0]        burst request: [0] block FSM, [1] board redraw, [2] score
//   x*/y*/c*/p*     pixel X, Y, colour and plot strobe of each requester
//   clear_start     one-cycle pulse asking for a full-screen clear
//   gnt[2:0]        one-hot grant to the external requesters
//   clear_busy      clear accepted and not yet finished
//   clear_done      one-cycle pulse while the last clear pixel is on vga_*
//   vga_x/vga_y/vga_colour/vga_plot   registered adapter write port
module vga_plot_arbiter #(
    parameter int unsigned XSCREEN      = 160,
    parameter int unsigned YSCREEN      = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [2:0] req,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [6:0] y2,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    input  logic [2:0] c2,
    input  logic       p0,
    input  logic       p1,
    input  logic       p2,
    input  logic       clear_start,
    output logic [2:0] gnt,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    localparam logic [1:0] SLOT_CLEAR = 2'd3;
    localparam logic [7:0] X_LAST     = 8'(XSCREEN - 1);
    localparam logic [6:0] Y_LAST     = 7'(YSCREEN - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [2:0] gnt_q, gnt_d;
    logic [7:0] sx_q, sx_d;
    logic [6:0] sy_q, sy_d;
    logic       pend_q, pend_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] vx_q, vx_d;
    logic [6:0] vy_q, vy_d;
    logic [2:0] vc_q, vc_d;
    logic       vp_q, vp_d;

    logic [3:0] slot_req;
    logic [1:0] cand;
    logic [1:0] pick;
    logic       pick_valid;

    logic [7:0] own_x;
    logic [6:0] own_y;
    logic [2:0] own_c;
    logic       own_p;
    logic       own_req;

    // Round-robin search starting at last_q+1. The 2-bit add wraps mod 4, so
    // the fourth candidate is last_q itself.
    always_comb begin
        slot_req   = {pend_q, req};
        cand       = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!pick_valid && slot_req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Data and request of the current external owner.
    always_comb begin
        own_x   = x0;
        own_y   = y0;
        own_c   = c0;
        own_p   = p0;
        own_req = req[0];
        case (owner_q)
            2'd1: begin
                own_x = x1; own_y = y1; own_c = c1; own_p = p1; own_req = req[1];
            end
            2'd2: begin
                own_x = x2; own_y = y2; own_c = c2; own_p = p2; own_req = req[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = '0;
        sx_d    = sx_q;
        sy_d    = sy_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        vp_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    owner_d = pick;
                    if (pick != SLOT_CLEAR) gnt_d = 3'b001 << pick;
                end
            end
            S_GRANT: begin
                if (owner_q == SLOT_CLEAR) begin
                    vx_d = sx_q;
                    vy_d = sy_q;
                    vc_d = CLEAR_COLOUR;
                    vp_d = 1'b1;
                    if (sx_q == X_LAST) begin
                        sx_d = '0;
                        if (sy_q == Y_LAST) begin
                            sy_d    = '0;
                            pend_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_RELEASE;
                        end else begin
                            sy_d = sy_q + 7'd1;
                        end
                    end else begin
                        sx_d = sx_q + 8'd1;
                    end
                end else begin
                    vx_d = own_x;
                    vy_d = own_y;
                    vc_d = own_c;
                    vp_d = own_p;
                    if (own_req) gnt_d   = gnt_q;
                    else         state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // busy has already dropped while clear_done is high, so done_q must
        // also block a start pulse in that cycle.
        if (clear_start && !busy_q && !done_q) begin
            pend_d = 1'b1;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= SLOT_CLEAR;
            gnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            vp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            vp_q    <= vp_d;
        end
    end

    assign gnt        = gnt_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = vp_q;

endmodule
